mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/cpu_pkg.sv | 13 +
 rtl/mem_wb_stage.sv | 128 ++++++++++++
 tb/tb_mem_wb_stage.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back stage state encoding and default widths.
package cpu_pkg;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: retires ALU/link results directly, sequences data-memory
// loads and stores through a req/gnt + rvalid handshake, and drives the register-file write port.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int RADDR_W = cpu_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [DATA_W-1:0]  data_out,
    input  logic [DATA_W-1:0]  st_data,
    input  logic [DATA_W-1:0]  link_pc,
    input  logic [RADDR_W-1:0] addr_dest,
    input  logic               mem_inst,
    input  logic               store,
    input  logic               WR,
    input  logic               link,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_gnt,
    input  logic               dmem_rvalid,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               rf_wen,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               busy
);

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [RADDR_W-1:0]   dest_q, dest_d;
    logic                 store_q, store_d;
    logic                 wr_q, wr_d;
    logic                 rf_wen_q, rf_wen_d;
    logic [RADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]    rf_wdata_q, rf_wdata_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dest_d     = dest_q;
        store_d    = store_q;
        wr_d       = wr_q;
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (mem_inst) begin
                        // link is meaningless for memory ops; only the access fields are kept
                        addr_d  = data_out;
                        wdata_d = st_data;
                        dest_d  = addr_dest;
                        store_d = store;
                        wr_d    = WR;
                        state_d = MEM_REQ;
                    end else begin
                        rf_wen_d = WR;
                        if (WR) begin
                            rf_waddr_d = addr_dest;
                            rf_wdata_d = link ? link_pc : data_out;
                        end
                    end
                end
            end
            MEM_REQ: begin
                if (dmem_gnt) begin
                    state_d = store_q ? IDLE : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_rvalid) begin
                    rf_wen_d = wr_q;
                    if (wr_q) begin
                        rf_waddr_d = dest_q;
                        rf_wdata_d = dmem_rdata;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            dest_q     <= '0;
            store_q    <= 1'b0;
            wr_q       <= 1'b0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dest_q     <= dest_d;
            store_q    <= store_d;
            wr_q       <= wr_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign ex_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign dmem_req   = (state_q == MEM_REQ);
    assign dmem_we    = (state_q == MEM_REQ) && store_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign rf_wen     = rf_wen_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized transactions against a register-write reference model.
module tb_mem_wb_stage;

    localparam int DW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_valid;
    logic          ex_ready;
    logic [DW-1:0] data_out;
    logic [DW-1:0] st_data;
    logic [DW-1:0] link_pc;
    logic [RW-1:0] addr_dest;
    logic          mem_inst;
    logic          store;
    logic          WR;
    logic          link;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_gnt;
    logic          dmem_rvalid;
    logic [DW-1:0] dmem_rdata;
    logic          rf_wen;
    logic [RW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Reference model: the last value committed to the register-file port
    logic [RW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;

    mem_wb_stage #(.DATA_W(DW), .RADDR_W(RW)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .data_out(data_out), .st_data(st_data), .link_pc(link_pc), .addr_dest(addr_dest),
        .mem_inst(mem_inst), .store(store), .WR(WR), .link(link),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid    = 1'b0;
        data_out    = '0;
        st_data     = '0;
        link_pc     = '0;
        addr_dest   = '0;
        mem_inst    = 1'b0;
        store       = 1'b0;
        WR          = 1'b0;
        link        = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, dmem_req, dmem_we, rf_wen} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/req/we/wen got %b%b%b%b required 0000", busy, dmem_req, dmem_we, rf_wen);
        end
        checks++;
        if (rf_waddr !== 3'd0 || rf_wdata !== 16'h0 || dmem_addr !== 16'h0 || dmem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: waddr=%h wdata=%h daddr=%h dwdata=%h required all 0", rf_waddr, rf_wdata, dmem_addr, dmem_wdata);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ex_ready got %b required 1", ex_ready);
        end
        m_waddr = '0;
        m_wdata = '0;
    endtask

    task automatic test_alu_write();
        ex_valid = 1'b1; mem_inst = 1'b0; link = 1'b0; WR = 1'b1;
        data_out = 16'h1234; addr_dest = 3'd3; link_pc = 16'h5555;
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL alu_ready: ex_ready got %b required 1", ex_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL alu_write: wen=%b waddr=%0d wdata=%h required 1/3/1234", rf_wen, rf_waddr, rf_wdata);
        end
        m_waddr = 3'd3; m_wdata = 16'h1234;
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
            errors++;
            $display("FAIL alu_hold: wen=%b waddr=%0d wdata=%h required 0/%0d/%h", rf_wen, rf_waddr, rf_wdata, m_waddr, m_wdata);
        end
    endtask

    task automatic test_link_write();
        ex_valid = 1'b1; mem_inst = 1'b0; link = 1'b1; WR = 1'b1;
        data_out = 16'hFFFF; link_pc = 16'h0042; addr_dest = 3'd7;
        tick();
        idle_inputs();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 3'd7 || rf_wdata !== 16'h0042) begin
            errors++;
            $display("FAIL link_write: wen=%b waddr=%0d wdata=%h required 1/7/0042", rf_wen, rf_waddr, rf_wdata);
        end
        m_waddr = 3'd7; m_wdata = 16'h0042;
        tick();
    endtask

    task automatic test_load();
        ex_valid = 1'b1; mem_inst = 1'b1; store = 1'b0; WR = 1'b1; link = 1'b0;
        data_out = 16'h0100; st_data = 16'h7777; addr_dest = 3'd5;
        tick();
        idle_inputs();
        data_out = 16'hDEAD;
        for (int g = 0; g < 3; g++) begin
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b1;
            dmem_rdata = 16'h1111;
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 16'h0100 || ex_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL load_req_wait%0d: req=%b we=%b addr=%h ready=%b busy=%b required 1/0/0100/0/1", g, dmem_req, dmem_we, dmem_addr, ex_ready, busy);
            end
            tick();
        end
        dmem_rvalid = 1'b0;
        dmem_gnt = 1'b1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL load_gnt: req=%b addr=%h required 1/0100", dmem_req, dmem_addr);
        end
        tick();
        dmem_gnt = 1'b1;
        checks++;
        if (dmem_req !== 1'b0 || ex_ready !== 1'b0 || rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL load_wait1: req=%b ready=%b wen=%b required 0/0/0", dmem_req, ex_ready, rf_wen);
        end
        tick();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 16'hBEEF;
        checks++;
        if (ex_ready !== 1'b0 || rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL load_wait2: ready=%b wen=%b required 0/0", ex_ready, rf_wen);
        end
        tick();
        idle_inputs();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 3'd5 || rf_wdata !== 16'hBEEF || ex_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_wb: wen=%b waddr=%0d wdata=%h ready=%b busy=%b required 1/5/BEEF/1/0", rf_wen, rf_waddr, rf_wdata, ex_ready, busy);
        end
        m_waddr = 3'd5; m_wdata = 16'hBEEF;
        tick();
    endtask

    task automatic test_store();
        ex_valid = 1'b1; mem_inst = 1'b1; store = 1'b1; WR = 1'b1; link = 1'b1;
        data_out = 16'h0200; st_data = 16'hA5A5; addr_dest = 3'd2; link_pc = 16'h0999;
        tick();
        idle_inputs();
        dmem_gnt = 1'b1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 16'h0200 || dmem_wdata !== 16'hA5A5 || ex_ready !== 1'b0) begin
            errors++;
            $display("FAIL store_req: req=%b we=%b addr=%h wdata=%h ready=%b required 1/1/0200/A5A5/0", dmem_req, dmem_we, dmem_addr, dmem_wdata, ex_ready);
        end
        tick();
        dmem_gnt = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || rf_wen !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_done: req=%b we=%b wen=%b ready=%b required 0/0/0/1", dmem_req, dmem_we, rf_wen, ex_ready);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
            errors++;
            $display("FAIL store_no_wb: wen=%b waddr=%0d wdata=%h required 0/%0d/%h", rf_wen, rf_waddr, rf_wdata, m_waddr, m_wdata);
        end
    endtask

    task automatic test_reset_mem_wait();
        ex_valid = 1'b1; mem_inst = 1'b1; store = 1'b0; WR = 1'b1;
        data_out = 16'h0300; addr_dest = 3'd6;
        tick();
        idle_inputs();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        checks++;
        if (busy !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL rstw_in_wait: busy=%b req=%b required 1/0", busy, dmem_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 16'hCAFE;
        tick();
        dmem_rvalid = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({busy, dmem_req, dmem_we, rf_wen} !== 4'b0000 || ex_ready !== 1'b1 ||
                rf_waddr !== 3'd0 || rf_wdata !== 16'h0 || dmem_addr !== 16'h0 || dmem_wdata !== 16'h0) begin
                errors++;
                $display("FAIL rstw_outputs%0d: busy=%b req=%b we=%b wen=%b ready=%b waddr=%0d wdata=%h daddr=%h dwdata=%h required reset values",
                         k, busy, dmem_req, dmem_we, rf_wen, ex_ready, rf_waddr, rf_wdata, dmem_addr, dmem_wdata);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] exp_a [4];
        logic [DW-1:0] exp_d [4];
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1; mem_inst = 1'b0; WR = 1'b1;
            link = 1'($urandom);
            data_out = 16'($urandom);
            link_pc = 16'($urandom);
            addr_dest = 3'(i + 1);
            exp_a[i] = addr_dest;
            exp_d[i] = link ? link_pc : data_out;
            checks++;
            if (ex_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: ex_ready got %b required 1", i, ex_ready);
            end
            tick();
            checks++;
            if (rf_wen !== 1'b1 || rf_waddr !== exp_a[i] || rf_wdata !== exp_d[i]) begin
                errors++;
                $display("FAIL b2b_write%0d: wen=%b waddr=%0d wdata=%h required 1/%0d/%h", i, rf_wen, rf_waddr, rf_wdata, exp_a[i], exp_d[i]);
            end
        end
        m_waddr = exp_a[3];
        m_wdata = exp_d[3];
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int kind, gd, rd;
        logic          t_wr, t_link, t_store, t_mem;
        logic [DW-1:0] t_addr, t_sdata, t_rdata;
        for (int n = 0; n < 60; n++) begin
            kind    = $urandom_range(0, 3);
            t_mem   = (kind >= 2);
            t_store = (kind == 3);
            t_link  = (kind == 1) ? 1'b1 : 1'($urandom);
            t_wr    = 1'($urandom);
            t_addr  = 16'($urandom);
            t_sdata = 16'($urandom);
            ex_valid = 1'b1; mem_inst = t_mem; store = t_store; WR = t_wr; link = t_link;
            data_out = t_addr; st_data = t_sdata; link_pc = 16'($urandom);
            addr_dest = 3'($urandom);
            checks++;
            if (ex_ready !== 1'b1) begin
                errors++;
                $display("FAIL rnd_ready%0d: ex_ready got %b required 1", n, ex_ready);
            end
            if (!t_mem && t_wr) begin
                m_waddr = addr_dest;
                m_wdata = t_link ? link_pc : t_addr;
            end
            t_rdata = 16'($urandom);
            if (t_mem && !t_store && t_wr) begin
                m_waddr = addr_dest;
                m_wdata = t_rdata;
            end
            tick();
            idle_inputs();
            data_out = 16'($urandom);
            st_data  = 16'($urandom);
            if (!t_mem) begin
                checks++;
                if (rf_wen !== t_wr || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                    errors++;
                    $display("FAIL rnd_alu%0d: wen=%b waddr=%0d wdata=%h required %b/%0d/%h", n, rf_wen, rf_waddr, rf_wdata, t_wr, m_waddr, m_wdata);
                end
            end else begin
                gd = $urandom_range(0, 3);
                for (int g = 0; g <= gd; g++) begin
                    dmem_gnt    = (g == gd);
                    dmem_rvalid = (g == gd) ? 1'b0 : 1'($urandom);
                    dmem_rdata  = 16'($urandom);
                    checks++;
                    if (dmem_req !== 1'b1 || dmem_addr !== t_addr || dmem_we !== t_store ||
                        (t_store && dmem_wdata !== t_sdata) || rf_wen !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd_req%0d: req=%b addr=%h we=%b wdata=%h wen=%b required 1/%h/%b/%h/0", n, dmem_req, dmem_addr, dmem_we, dmem_wdata, rf_wen, t_addr, t_store, t_sdata);
                    end
                    tick();
                end
                idle_inputs();
                if (!t_store) begin
                    rd = $urandom_range(0, 3);
                    for (int r = 0; r < rd; r++) begin
                        dmem_gnt = 1'($urandom);
                        checks++;
                        if (ex_ready !== 1'b0 || dmem_req !== 1'b0 || rf_wen !== 1'b0) begin
                            errors++;
                            $display("FAIL rnd_wait%0d: ready=%b req=%b wen=%b required 0/0/0", n, ex_ready, dmem_req, rf_wen);
                        end
                        tick();
                    end
                    dmem_gnt = 1'b0;
                    dmem_rvalid = 1'b1;
                    dmem_rdata = t_rdata;
                    tick();
                    idle_inputs();
                    checks++;
                    if (rf_wen !== t_wr || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                        errors++;
                        $display("FAIL rnd_load%0d: wen=%b waddr=%0d wdata=%h required %b/%0d/%h", n, rf_wen, rf_waddr, rf_wdata, t_wr, m_waddr, m_wdata);
                    end
                end else begin
                    checks++;
                    if (rf_wen !== 1'b0 || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                        errors++;
                        $display("FAIL rnd_store%0d: wen=%b waddr=%0d wdata=%h required 0/%0d/%h", n, rf_wen, rf_waddr, rf_wdata, m_waddr, m_wdata);
                    end
                end
                checks++;
                if (ex_ready !== 1'b1 || dmem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_back_idle%0d: ready=%b req=%b required 1/0", n, ex_ready, dmem_req);
                end
            end
            // Idle gap with stray handshakes that must be ignored
            if ($urandom_range(0, 1) == 1) begin
                dmem_gnt    = 1'($urandom);
                dmem_rvalid = 1'($urandom);
                dmem_rdata  = 16'($urandom);
                tick();
                idle_inputs();
                checks++;
                if (rf_wen !== 1'b0 || busy !== 1'b0 || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                    errors++;
                    $display("FAIL rnd_gap%0d: wen=%b busy=%b waddr=%0d wdata=%h required 0/0/%0d/%h", n, rf_wen, busy, rf_waddr, rf_wdata, m_waddr, m_wdata);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_alu_write();
        test_link_write();
        test_load();
        test_store();
        test_reset_mem_wait();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
